// File: rtl/branch_resolution_arbiter.sv
// Branch resolution arbiter: picks the oldest mispredicting lane by ROB age,
// issues a registered redirect/flush, and serialises predictor updates via a FIFO.
module branch_resolution_arbiter #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ROB_IDX_W    = 5,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned UPD_DEPTH    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  misprediction_0,
    input  logic                  misprediction_1,
    input  logic                  misprediction_2,
    input  logic [DATA_WIDTH-1:0] correct_pc_0,
    input  logic [DATA_WIDTH-1:0] correct_pc_1,
    input  logic [DATA_WIDTH-1:0] correct_pc_2,
    input  logic                  update_predictor_0,
    input  logic                  update_predictor_1,
    input  logic                  update_predictor_2,
    input  logic [DATA_WIDTH-1:0] update_pc_0,
    input  logic [DATA_WIDTH-1:0] update_pc_1,
    input  logic [DATA_WIDTH-1:0] update_pc_2,
    input  logic [ROB_IDX_W-1:0]  rob_idx_0,
    input  logic [ROB_IDX_W-1:0]  rob_idx_1,
    input  logic [ROB_IDX_W-1:0]  rob_idx_2,
    input  logic [ROB_IDX_W-1:0]  rob_head,
    output logic                  redirect_valid,
    output logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  flush,
    output logic [ROB_IDX_W-1:0]  flush_rob_idx,
    output logic                  pred_upd_valid,
    output logic [DATA_WIDTH-1:0] pred_upd_pc,
    output logic                  pred_upd_mispredict,
    input  logic                  pred_upd_ready,
    output logic                  upd_overflow
);

    localparam int unsigned LANES = 3;
    localparam int unsigned AW    = $clog2(UPD_DEPTH);
    localparam int unsigned PW    = AW + 1;
    localparam int unsigned CW    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t                  state, state_d;
    logic [CW-1:0]           cnt, cnt_d;
    logic                    redirect_valid_d, flush_d;
    logic [DATA_WIDTH-1:0]   redirect_pc_d;
    logic [ROB_IDX_W-1:0]    flush_rob_idx_d;

    logic [LANES-1:0]        mis, upd;
    logic [DATA_WIDTH-1:0]   cpc [LANES];
    logic [DATA_WIDTH-1:0]   upc [LANES];
    logic [ROB_IDX_W-1:0]    tag [LANES];
    logic [ROB_IDX_W-1:0]    age [LANES];

    logic                    win_found, take, in_flush;
    logic [ROB_IDX_W-1:0]    win_age, win_tag, held_age;
    logic [DATA_WIDTH-1:0]   win_pc;

    logic [DATA_WIDTH:0]     mem [UPD_DEPTH];
    logic [PW-1:0]           wr_ptr, rd_ptr, wr_ptr_d, count, free, slot;
    logic [LANES-1:0]        acc;
    logic [AW-1:0]           waddr [LANES];
    logic                    pop, drop;

    assign mis    = {misprediction_2, misprediction_1, misprediction_0};
    assign upd    = {update_predictor_2, update_predictor_1, update_predictor_0};
    assign cpc[0] = correct_pc_0;
    assign cpc[1] = correct_pc_1;
    assign cpc[2] = correct_pc_2;
    assign upc[0] = update_pc_0;
    assign upc[1] = update_pc_1;
    assign upc[2] = update_pc_2;
    assign tag[0] = rob_idx_0;
    assign tag[1] = rob_idx_1;
    assign tag[2] = rob_idx_2;

    assign in_flush = (state == FLUSH);
    assign held_age = flush_rob_idx - rob_head;

    // Age of each lane relative to the ROB head, then oldest mispredicting lane
    always_comb begin
        win_found = 1'b0;
        win_age   = '1;
        win_tag   = '0;
        win_pc    = '0;
        for (int unsigned n = 0; n < LANES; n++) begin
            age[n] = tag[n] - rob_head;
            if (mis[n] && (!win_found || age[n] < win_age)) begin
                win_found = 1'b1;
                win_age   = age[n];
                win_tag   = tag[n];
                win_pc    = cpc[n];
            end
        end
        take = win_found && (!in_flush || win_age < held_age);
    end

    // Redirect/flush FSM next state and registered-output next values
    always_comb begin
        state_d          = state;
        cnt_d            = cnt;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc;
        flush_rob_idx_d  = flush_rob_idx;
        if (take) begin
            redirect_valid_d = 1'b1;
            redirect_pc_d    = win_pc & ~DATA_WIDTH'(3);
            flush_rob_idx_d  = win_tag;
        end
        case (state)
            IDLE: begin
                if (take) begin
                    state_d = FLUSH;
                    cnt_d   = CW'(FLUSH_CYCLES - 1);
                end
            end
            FLUSH: begin
                if (take) begin
                    cnt_d = CW'(FLUSH_CYCLES - 1);
                end else if (cnt == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        flush_d = (state_d == FLUSH);
    end

    assign count               = wr_ptr - rd_ptr;
    assign pred_upd_valid      = (wr_ptr != rd_ptr);
    assign pop                 = pred_upd_valid && pred_upd_ready;
    assign free                = PW'(UPD_DEPTH) - count + PW'(pop);
    assign pred_upd_pc         = pred_upd_valid ? mem[rd_ptr[AW-1:0]][DATA_WIDTH-1:0] : '0;
    assign pred_upd_mispredict = pred_upd_valid & mem[rd_ptr[AW-1:0]][DATA_WIDTH];

    // Admit eligible updates in lane order into the free slots; flag the rest as dropped
    always_comb begin
        slot = '0;
        acc  = '0;
        drop = 1'b0;
        for (int unsigned n = 0; n < LANES; n++) begin
            waddr[n] = '0;
            if (upd[n] && !(win_found && age[n] > win_age) && !(in_flush && age[n] > held_age)) begin
                if (slot < free) begin
                    acc[n]   = 1'b1;
                    waddr[n] = wr_ptr[AW-1:0] + slot[AW-1:0];
                    slot     = slot + PW'(1);
                end else begin
                    drop = 1'b1;
                end
            end
        end
        wr_ptr_d = wr_ptr + slot;
    end

    // FIFO storage: {mispredict, pc}
    always_ff @(posedge clk) begin
        for (int unsigned n = 0; n < LANES; n++) begin
            if (acc[n]) begin
                mem[waddr[n]] <= {mis[n], upc[n]};
            end
        end
    end

    // State, counters, pointers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush          <= 1'b0;
            flush_rob_idx  <= '0;
            upd_overflow   <= 1'b0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
        end else begin
            state          <= state_d;
            cnt            <= cnt_d;
            redirect_valid <= redirect_valid_d;
            redirect_pc    <= redirect_pc_d;
            flush          <= flush_d;
            flush_rob_idx  <= flush_rob_idx_d;
            upd_overflow   <= drop;
            wr_ptr         <= wr_ptr_d;
            rd_ptr         <= rd_ptr + PW'(pop);
        end
    end

endmodule

// File: tb/tb_branch_resolution_arbiter.sv
// Self-checking bench for branch_resolution_arbiter: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_branch_resolution_arbiter;

    localparam int DW    = 32;
    localparam int RW    = 5;
    localparam int FC    = 2;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [2:0]    mis, upd;
    logic [DW-1:0] cpc [3];
    logic [DW-1:0] upc [3];
    logic [RW-1:0] tag [3];
    logic [RW-1:0] rob_head;
    logic          ready;

    logic          redirect_valid, flush, pred_upd_valid, pred_upd_mispredict, upd_overflow;
    logic [DW-1:0] redirect_pc, pred_upd_pc;
    logic [RW-1:0] flush_rob_idx;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [DW:0]   mq [$];
    int            m_rem;
    logic [RW-1:0] m_tag;
    logic [DW-1:0] m_rpc;
    logic          m_rv, m_ovf;

    branch_resolution_arbiter #(
        .DATA_WIDTH(DW), .ROB_IDX_W(RW), .FLUSH_CYCLES(FC), .UPD_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .misprediction_0(mis[0]), .misprediction_1(mis[1]), .misprediction_2(mis[2]),
        .correct_pc_0(cpc[0]), .correct_pc_1(cpc[1]), .correct_pc_2(cpc[2]),
        .update_predictor_0(upd[0]), .update_predictor_1(upd[1]), .update_predictor_2(upd[2]),
        .update_pc_0(upc[0]), .update_pc_1(upc[1]), .update_pc_2(upc[2]),
        .rob_idx_0(tag[0]), .rob_idx_1(tag[1]), .rob_idx_2(tag[2]),
        .rob_head(rob_head),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush(flush), .flush_rob_idx(flush_rob_idx),
        .pred_upd_valid(pred_upd_valid), .pred_upd_pc(pred_upd_pc),
        .pred_upd_mispredict(pred_upd_mispredict), .pred_upd_ready(ready),
        .upd_overflow(upd_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] expd);
        checks++;
        assert (obs === expd) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, expd);
        end
    endtask

    task automatic clear_inputs();
        mis = '0; upd = '0; ready = 1'b0; rob_head = '0;
        for (int i = 0; i < 3; i++) begin
            cpc[i] = '0; upc[i] = '0; tag[i] = RW'(i);
        end
    endtask

    task automatic rand_inputs();
        rob_head = RW'($urandom_range(31));
        tag[0]   = RW'($urandom_range(31));
        do tag[1] = RW'($urandom_range(31)); while (tag[1] == tag[0]);
        do tag[2] = RW'($urandom_range(31)); while (tag[2] == tag[0] || tag[2] == tag[1]);
        for (int i = 0; i < 3; i++) begin
            mis[i] = ($urandom_range(3) == 0);
            upd[i] = $urandom_range(1) == 1;
            cpc[i] = $urandom;
            upc[i] = $urandom;
        end
        ready = $urandom_range(1) == 1;
    endtask

    task automatic model_reset();
        mq.delete();
        m_rem = 0; m_tag = '0; m_rpc = '0; m_rv = 1'b0; m_ovf = 1'b0;
    endtask

    function automatic int age_of(input logic [RW-1:0] t);
        return (int'(t) - int'(rob_head) + 32) % 32;
    endfunction

    // One clock of the reference model: oldest-wins, queue pushes in lane order, FIFO cap
    task automatic model_step();
        int  ages [3];
        int  wl, hage, free;
        bit  busy, qual;
        wl = -1;
        for (int i = 0; i < 3; i++) begin
            ages[i] = age_of(tag[i]);
            if (mis[i] && (wl < 0 || ages[i] < ages[wl])) wl = i;
        end
        busy = (m_rem > 0);
        hage = age_of(m_tag);
        qual = (wl >= 0) && (!busy || ages[wl] < hage);
        if (mq.size() > 0 && ready) void'(mq.pop_front());
        free  = DEPTH - mq.size();
        m_ovf = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (upd[i] && !(wl >= 0 && ages[i] > ages[wl]) && !(busy && ages[i] > hage)) begin
                if (free > 0) begin
                    mq.push_back({mis[i], upc[i]});
                    free--;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        if (qual) begin
            m_rv  = 1'b1;
            m_rpc = {cpc[wl][DW-1:2], 2'b00};
            m_tag = tag[wl];
            m_rem = FC;
        end else begin
            m_rv = 1'b0;
            if (m_rem > 0) m_rem--;
        end
    endtask

    task automatic check_all();
        check("flush", 64'(flush), 64'(m_rem > 0));
        check("redirect_valid", 64'(redirect_valid), 64'(m_rv));
        check("redirect_pc", 64'(redirect_pc), 64'(m_rpc));
        check("flush_rob_idx", 64'(flush_rob_idx), 64'(m_tag));
        check("upd_overflow", 64'(upd_overflow), 64'(m_ovf));
        check("pred_upd_valid", 64'(pred_upd_valid), 64'(mq.size() > 0));
        if (mq.size() > 0) begin
            check("pred_upd_pc", 64'(pred_upd_pc), 64'(mq[0][DW-1:0]));
            check("pred_upd_mispredict", 64'(pred_upd_mispredict), 64'(mq[0][DW]));
        end else begin
            check("pred_upd_pc_idle", 64'(pred_upd_pc), 64'd0);
        end
    endtask

    task automatic run_cycle();
        model_step();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        // reset held while inputs toggle
        clear_inputs();
        model_reset();
        rst_n = 1'b0;
        repeat (4) begin
            @(negedge clk);
            rand_inputs();
            #1;
            check_all();
        end
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b1;
        run_cycle();
        check("rel_pred_upd_valid", 64'(pred_upd_valid), 64'd0);
        check("rel_flush", 64'(flush), 64'd0);

        // oldest misprediction wins across the tag wrap
        rob_head = RW'(30); mis = 3'b111;
        tag[0] = RW'(2); tag[1] = RW'(31); tag[2] = RW'(5);
        cpc[0] = 32'h100; cpc[1] = 32'h204; cpc[2] = 32'h300;
        run_cycle();
        check("t2_rv", 64'(redirect_valid), 64'd1);
        check("t2_pc", 64'(redirect_pc), 64'h204);
        check("t2_idx", 64'(flush_rob_idx), 64'd31);
        check("t2_flush0", 64'(flush), 64'd1);
        mis = '0;
        run_cycle();
        check("t2_rv_pulse", 64'(redirect_valid), 64'd0);
        check("t2_flush1", 64'(flush), 64'd1);
        run_cycle();
        check("t2_flush_end", 64'(flush), 64'd0);

        // older misprediction overrides during flush; younger one ignored
        clear_inputs();
        mis[0] = 1'b1; tag[0] = RW'(10); cpc[0] = 32'h1002;
        run_cycle();
        check("t3_idx10", 64'(flush_rob_idx), 64'd10);
        check("t3_pc10", 64'(redirect_pc), 64'h1000);
        clear_inputs();
        mis[2] = 1'b1; tag[2] = RW'(4); cpc[2] = 32'h40;
        run_cycle();
        check("t3_rv_re", 64'(redirect_valid), 64'd1);
        check("t3_pc_re", 64'(redirect_pc), 64'h40);
        check("t3_idx_re", 64'(flush_rob_idx), 64'd4);
        clear_inputs();
        mis[0] = 1'b1; tag[0] = RW'(12); cpc[0] = 32'h500;
        run_cycle();
        check("t3_ign_rv", 64'(redirect_valid), 64'd0);
        check("t3_ign_idx", 64'(flush_rob_idx), 64'd4);
        check("t3_ext_flush", 64'(flush), 64'd1);
        clear_inputs();
        run_cycle();
        check("t3_flush_end", 64'(flush), 64'd0);

        // update ordering and squash of lanes younger than the winner
        clear_inputs();
        upd = 3'b111; tag[0] = RW'(1); tag[1] = RW'(2); tag[2] = RW'(3);
        upc[0] = 32'hA0; upc[1] = 32'hB0; upc[2] = 32'hC0;
        mis[1] = 1'b1; cpc[1] = 32'h800; ready = 1'b1;
        run_cycle();
        check("t4_head0", 64'(pred_upd_pc), 64'hA0);
        check("t4_mis0", 64'(pred_upd_mispredict), 64'd0);
        clear_inputs(); ready = 1'b1;
        run_cycle();
        check("t4_head1", 64'(pred_upd_pc), 64'hB0);
        check("t4_mis1", 64'(pred_upd_mispredict), 64'd1);
        run_cycle();
        check("t4_empty", 64'(pred_upd_valid), 64'd0);

        // overflow at capacity, then pop+push at full
        clear_inputs();
        for (int c = 0; c < 3; c++) begin
            upd = 3'b111;
            for (int i = 0; i < 3; i++) upc[i] = 32'h1000 + 32'(c * 16 + i * 4);
            run_cycle();
            check("t5_ovf", 64'(upd_overflow), 64'(c == 2));
        end
        upd = 3'b001; upc[0] = 32'h2000; ready = 1'b1;
        run_cycle();
        check("t5_full_pp_ovf", 64'(upd_overflow), 64'd0);
        upd = '0;
        repeat (9) run_cycle();
        check("t5_drained", 64'(pred_upd_valid), 64'd0);

        // randomized traffic
        repeat (3000) begin
            rand_inputs();
            run_cycle();
        end

        // asynchronous reset mid-flush with the FIFO holding data
        clear_inputs();
        repeat (3) run_cycle();
        upd = 3'b111; tag[0] = RW'(1); tag[1] = RW'(2); tag[2] = RW'(3);
        mis[0] = 1'b1; cpc[0] = 32'h100; upc[0] = 32'h3000;
        run_cycle();
        check("t6_pre_flush", 64'(flush), 64'd1);
        check("t6_pre_valid", 64'(pred_upd_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_flush", 64'(flush), 64'd0);
        check("t6_valid", 64'(pred_upd_valid), 64'd0);
        check("t6_rv", 64'(redirect_valid), 64'd0);
        check("t6_idx", 64'(flush_rob_idx), 64'd0);
        model_reset();
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b1;
        repeat (2) run_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
